// File: rtl/hazard_fwd_unit_pkg.sv
// hazard_fwd_unit_pkg: shared CPU constants for operand forwarding and hazard detection
package hazard_fwd_unit_pkg;
  localparam int REGW_DEF = 5;
  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_EXM = 2'b10
  } fwd_e;
  function automatic fwd_e fwd_pick(input logic use_src, input logic ex_hit, input logic mem_hit);
    return !use_src ? FWD_RF : ex_hit ? FWD_EXM : mem_hit ? FWD_WB : FWD_RF;
  endfunction
endpackage

// File: rtl/hazard_fwd_unit_slot.sv
// hz_slot: one pipeline shadow slot {valid, rd, wr, load}; bubble inserts an invalid entry
module hz_slot #(
  parameter int REGW = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            bubble,
  input  logic            src_valid,
  input  logic [REGW-1:0] src_rd,
  input  logic            src_wr,
  input  logic            src_load,
  output logic            valid,
  output logic [REGW-1:0] rd,
  output logic            wr,
  output logic            load
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      rd    <= '0;
      wr    <= 1'b0;
      load  <= 1'b0;
    end else begin
      valid <= src_valid & ~bubble;
      rd    <= src_rd;
      wr    <= src_wr;
      load  <= src_load;
    end
  end
endmodule

// File: rtl/hazard_fwd_unit.sv
// hazard_fwd_unit: EX operand forwarding selects, load-use stall and flush bubbling
module hazard_fwd_unit
  import hazard_fwd_unit_pkg::*;
#(
  parameter int REGW = REGW_DEF,
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            id_valid,
  input  logic [REGW-1:0] id_rs,
  input  logic [REGW-1:0] id_rt,
  input  logic            id_use_rs,
  input  logic            id_use_rt,
  input  logic [REGW-1:0] id_rd,
  input  logic            id_wr,
  input  logic            id_load,
  input  logic            ex_flush,
  output logic [1:0]      fwd_a,
  output logic [1:0]      fwd_b,
  output logic            stall_if_id,
  output logic            bubble_ex,
  output logic [CNTW-1:0] stall_cnt
);
  logic            ex_valid, mem_valid, wb_valid;
  logic [REGW-1:0] ex_rd, mem_rd, wb_rd;
  logic            ex_wr, mem_wr, wb_wr;
  logic            ex_load, mem_load, wb_load;
  logic            use_a, use_b, ex_hit_a, ex_hit_b, mem_hit_a, mem_hit_b, load_use;
  fwd_e            fwd_a_q, fwd_b_q;

  hz_slot #(.REGW(REGW)) u_ex (
    .clk(clk), .rst_n(rst_n), .bubble(bubble_ex),
    .src_valid(id_valid), .src_rd(id_rd), .src_wr(id_wr), .src_load(id_load),
    .valid(ex_valid), .rd(ex_rd), .wr(ex_wr), .load(ex_load)
  );
  hz_slot #(.REGW(REGW)) u_mem (
    .clk(clk), .rst_n(rst_n), .bubble(1'b0),
    .src_valid(ex_valid), .src_rd(ex_rd), .src_wr(ex_wr), .src_load(ex_load),
    .valid(mem_valid), .rd(mem_rd), .wr(mem_wr), .load(mem_load)
  );
  hz_slot #(.REGW(REGW)) u_wb (
    .clk(clk), .rst_n(rst_n), .bubble(1'b0),
    .src_valid(mem_valid), .src_rd(mem_rd), .src_wr(mem_wr), .src_load(mem_load),
    .valid(wb_valid), .rd(wb_rd), .wr(wb_wr), .load(wb_load)
  );

  assign use_a     = id_valid & id_use_rs;
  assign use_b     = id_valid & id_use_rt;
  assign ex_hit_a  = ex_valid & ex_wr & (ex_rd == id_rs) & (id_rs != '0);
  assign ex_hit_b  = ex_valid & ex_wr & (ex_rd == id_rt) & (id_rt != '0);
  assign mem_hit_a = mem_valid & mem_wr & (mem_rd == id_rs) & (id_rs != '0);
  assign mem_hit_b = mem_valid & mem_wr & (mem_rd == id_rt) & (id_rt != '0);
  // A load result only exists after MEM, so an EX-slot load feeding ID must wait one cycle
  assign load_use  = ex_hit_a & use_a & ex_load | ex_hit_b & use_b & ex_load;

  assign stall_if_id = rst_n & load_use & ~ex_flush;
  assign bubble_ex   = rst_n & (load_use | ex_flush);
  assign fwd_a       = fwd_a_q;
  assign fwd_b       = fwd_b_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwd_a_q   <= FWD_RF;
      fwd_b_q   <= FWD_RF;
      stall_cnt <= '0;
    end else begin
      fwd_a_q   <= bubble_ex ? FWD_RF : fwd_pick(use_a, ex_hit_a, mem_hit_a);
      fwd_b_q   <= bubble_ex ? FWD_RF : fwd_pick(use_b, ex_hit_b, mem_hit_b);
      stall_cnt <= (stall_if_id && stall_cnt != '1) ? stall_cnt + 1'b1 : stall_cnt;
    end
  end
endmodule

// File: tb/tb_hazard_fwd_unit.sv
// tb_hazard_fwd_unit: scenario-driven scoreboard bench for hazard_fwd_unit
module tb_hazard_fwd_unit;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        id_valid = 1'b0, id_use_rs = 1'b0, id_use_rt = 1'b0, id_wr = 1'b0, id_load = 1'b0, ex_flush = 1'b0;
  logic [4:0]  id_rs = '0, id_rt = '0, id_rd = '0;
  logic [1:0]  fwd_a, fwd_b;
  logic        stall_if_id, bubble_ex;
  logic [15:0] stall_cnt;
  logic [3:0]  exp_q[$];
  int          n_vec = 0, n_err = 0;

  always #5 clk = ~clk;

  hazard_fwd_unit dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_rd(id_rd), .id_wr(id_wr),
    .id_load(id_load), .ex_flush(ex_flush), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .stall_if_id(stall_if_id), .bubble_ex(bubble_ex), .stall_cnt(stall_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Drive one ID instruction; stall/bubble are checked in-cycle, fwd codes one cycle later via the queue
  task automatic issue(input string t, input logic v, input logic [4:0] rs, input logic [4:0] rt,
                       input logic urs, input logic urt, input logic [4:0] rd, input logic wr,
                       input logic ld, input logic fl, input logic es, input logic eb,
                       input logic [1:0] ea, input logic [1:0] ebb, input int cnt);
    logic [3:0] e;
    id_valid = v; id_rs = rs; id_rt = rt; id_use_rs = urs; id_use_rt = urt;
    id_rd = rd; id_wr = wr; id_load = ld; ex_flush = fl;
    @(negedge clk);
    chk({t, ".stall"}, 32'(stall_if_id), 32'(es));
    chk({t, ".bubble"}, 32'(bubble_ex), 32'(eb));
    exp_q.push_back({ea, ebb});
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk({t, ".fwd_a"}, 32'(fwd_a), 32'(e[3:2]));
    chk({t, ".fwd_b"}, 32'(fwd_b), 32'(e[1:0]));
    chk({t, ".cnt"}, 32'(stall_cnt), 32'(cnt));
  endtask

  task automatic nop(input int cnt);
    issue("nop", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, cnt);
  endtask

  initial begin
    id_valid = 1; id_rs = 5'd3; id_rt = 5'd3; id_use_rs = 1; id_use_rt = 1;
    #12;
    chk("rst.fwd_a", 32'(fwd_a), 0);
    chk("rst.fwd_b", 32'(fwd_b), 0);
    chk("rst.stall", 32'(stall_if_id), 0);
    chk("rst.bubble", 32'(bubble_ex), 0);
    chk("rst.cnt", 32'(stall_cnt), 0);
    @(posedge clk); #1 rst_n = 1;
    nop(0); nop(0);
    // EX forward: add r3,r1,r2 ; sub r4,r3,r1
    issue("exf.add", 1, 1, 2, 1, 1, 3, 1, 0, 0, 0, 0, 2'b00, 2'b00, 0);
    issue("exf.sub", 1, 3, 1, 1, 1, 4, 1, 0, 0, 0, 0, 2'b10, 2'b00, 0);
    nop(0); nop(0);
    // MEM forward on rt
    issue("memf.add", 1, 1, 2, 1, 1, 3, 1, 0, 0, 0, 0, 2'b00, 2'b00, 0);
    issue("memf.or", 1, 8, 9, 1, 1, 7, 1, 0, 0, 0, 0, 2'b00, 2'b00, 0);
    issue("memf.use", 1, 1, 3, 1, 1, 10, 1, 0, 0, 0, 0, 2'b00, 2'b01, 0);
    nop(0); nop(0);
    // Both slots produce r3: youngest wins
    issue("pri.p1", 1, 1, 2, 1, 1, 3, 1, 0, 0, 0, 0, 2'b00, 2'b00, 0);
    issue("pri.p2", 1, 4, 2, 1, 1, 3, 1, 0, 0, 0, 0, 2'b00, 2'b00, 0);
    issue("pri.use", 1, 3, 3, 1, 1, 11, 1, 0, 0, 0, 0, 2'b10, 2'b10, 0);
    nop(0); nop(0);
    // Unused source and invalid ID never forward
    issue("use.p", 1, 1, 2, 1, 1, 3, 1, 0, 0, 0, 0, 2'b00, 2'b00, 0);
    issue("use.rs0", 1, 3, 3, 0, 1, 12, 1, 0, 0, 0, 0, 2'b00, 2'b10, 0);
    issue("use.inv", 0, 3, 3, 1, 1, 12, 1, 0, 0, 0, 0, 2'b00, 2'b00, 0);
    nop(0); nop(0);
    // Load-use: lw r5 ; add r6,r5,r5
    issue("lu.lw", 1, 1, 0, 1, 0, 5, 1, 1, 0, 0, 0, 2'b00, 2'b00, 0);
    issue("lu.stall", 1, 5, 5, 1, 1, 6, 1, 0, 0, 1, 1, 2'b00, 2'b00, 1);
    issue("lu.go", 1, 5, 5, 1, 1, 6, 1, 0, 0, 0, 0, 2'b01, 2'b01, 1);
    nop(1); nop(1);
    // r0 is never forwarded or stalled on
    issue("r0.add", 1, 1, 2, 1, 1, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00, 1);
    issue("r0.use", 1, 0, 0, 1, 1, 6, 1, 0, 0, 0, 0, 2'b00, 2'b00, 1);
    issue("r0.lw", 1, 1, 0, 1, 0, 0, 1, 1, 0, 0, 0, 2'b00, 2'b00, 1);
    issue("r0.luse", 1, 0, 0, 1, 1, 6, 1, 0, 0, 0, 0, 2'b00, 2'b00, 1);
    nop(1); nop(1);
    // Flush beats load-use
    issue("fl.lw", 1, 1, 0, 1, 0, 5, 1, 1, 0, 0, 0, 2'b00, 2'b00, 1);
    issue("fl.add", 1, 5, 5, 1, 1, 6, 1, 0, 1, 0, 1, 2'b00, 2'b00, 1);
    nop(1); nop(1);
    // Reset asserted in the middle of a stall
    issue("rs.lw", 1, 1, 0, 1, 0, 5, 1, 1, 0, 0, 0, 2'b00, 2'b00, 1);
    id_valid = 1; id_rs = 5; id_rt = 5; id_use_rs = 1; id_use_rt = 1;
    id_rd = 6; id_wr = 1; id_load = 0; ex_flush = 0;
    @(negedge clk);
    chk("rs.pre_stall", 32'(stall_if_id), 1);
    rst_n = 0;
    #1;
    chk("rs.stall", 32'(stall_if_id), 0);
    chk("rs.bubble", 32'(bubble_ex), 0);
    chk("rs.fwd_a", 32'(fwd_a), 0);
    chk("rs.fwd_b", 32'(fwd_b), 0);
    chk("rs.cnt", 32'(stall_cnt), 0);
    @(posedge clk); #1 rst_n = 1;
    issue("rs.after", 1, 5, 5, 1, 1, 6, 1, 0, 0, 0, 0, 2'b00, 2'b00, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
